// File: rtl/alu_share_arbiter_if.sv
// Handshake and ALU-side bundle for alu_share_arbiter: two requesters, ALU drive/sample, one response channel.
// The slave modport is the arbiter; the master modport is the requesters/ALU/consumer environment.
interface alu_share_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0_valid;
  logic            req0_ready;
  logic [XLEN-1:0] req0_in1;
  logic [XLEN-1:0] req0_in2;
  logic [2:0]      req0_func3;
  logic            req0_opequal;

  logic            req1_valid;
  logic            req1_ready;
  logic [XLEN-1:0] req1_in1;
  logic [XLEN-1:0] req1_in2;
  logic [2:0]      req1_func3;
  logic            req1_opequal;

  logic [XLEN-1:0] alu_in1;
  logic [XLEN-1:0] alu_in2;
  logic [2:0]      alu_func3;
  logic            alu_opequal;
  logic [XLEN-1:0] alu_out;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_id;
  logic            busy;

  modport slave (
    input  req0_valid, req0_in1, req0_in2, req0_func3, req0_opequal,
    output req0_ready,
    input  req1_valid, req1_in1, req1_in2, req1_func3, req1_opequal,
    output req1_ready,
    output alu_in1, alu_in2, alu_func3, alu_opequal,
    input  alu_out,
    output rsp_valid, rsp_data, rsp_id,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_in1, req0_in2, req0_func3, req0_opequal,
    input  req0_ready,
    output req1_valid, req1_in1, req1_in2, req1_func3, req1_opequal,
    input  req1_ready,
    input  alu_in1, alu_in2, alu_func3, alu_opequal,
    output alu_out,
    input  rsp_valid, rsp_data, rsp_id,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between the execute stage (id 0) and the address/branch unit (id 1).
// Define ALU_ARB_RR_EN for round-robin arbitration; undefined gives fixed priority to requester 0.
module alu_share_arbiter #(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_in1;
  logic [XLEN-1:0] r_in2;
  logic [2:0]      r_func3;
  logic            r_opequal;
  logic            r_id;
  logic            r_rspValid;
  logic [XLEN-1:0] r_rspData;
  logic            r_rspId;

  logic w_accept;
  logic w_ptr;
  logic w_grant0;
  logic w_grant1;
  logic w_grant;

`ifdef ALU_ARB_RR_EN
  logic r_ptr;

  // Pointer names the requester that wins the next tie; it moves to the loser after every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_grant) begin
      r_ptr <= w_grant0;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b0;
`endif

  // A finishing response frees the ALU slot in the same cycle, so RESP can hand straight to EXEC.
  assign w_accept = (r_state == IDLE) || ((r_state == RESP) && bus.rsp_ready);
  assign w_grant0 = w_accept && bus.req0_valid && (!bus.req1_valid || !w_ptr);
  assign w_grant1 = w_accept && bus.req1_valid && (!bus.req0_valid || w_ptr);
  assign w_grant  = w_grant0 || w_grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_in1      <= '0;
      r_in2      <= '0;
      r_func3    <= '0;
      r_opequal  <= 1'b0;
      r_id       <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_rspId    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_in1     <= w_grant1 ? bus.req1_in1     : bus.req0_in1;
        r_in2     <= w_grant1 ? bus.req1_in2     : bus.req0_in2;
        r_func3   <= w_grant1 ? bus.req1_func3   : bus.req0_func3;
        r_opequal <= w_grant1 ? bus.req1_opequal : bus.req0_opequal;
        r_id      <= w_grant1;
      end
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_rspData  <= bus.alu_out;
          r_rspId    <= r_id;
          r_rspValid <= 1'b1;
          r_state    <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rspValid <= 1'b0;
            r_state    <= w_grant ? EXEC : IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready  = w_grant0;
  assign bus.req1_ready  = w_grant1;
  assign bus.alu_in1     = r_in1;
  assign bus.alu_in2     = r_in2;
  assign bus.alu_func3   = r_func3;
  assign bus.alu_opequal = r_opequal;
  assign bus.rsp_valid   = r_rspValid;
  assign bus.rsp_data    = r_rspData;
  assign bus.rsp_id      = r_rspId;
  assign bus.busy        = (r_state != IDLE);

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters: requester 0 is the execute stage, requester 1 is the address/branch-compare unit.
- Each requester presents an operation (in1, in2, func3, opequal) with a valid/ready handshake.
- The block grants one request, latches its operands, drives the ALU for one cycle, registers the result and returns it on one response channel tagged with the requester id.
- The ALU is external; this block drives its inputs and samples its output.

Parameters:
- XLEN, 32, operand and result width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 operation valid
- req0_ready  out  1  requester 0 accepted this cycle
- req0_in1  in  XLEN  requester 0 operand 1
- req0_in2  in  XLEN  requester 0 operand 2
- req0_func3  in  3  requester 0 ALU func3
- req0_opequal  in  1  requester 0 sub/arith qualifier
- req1_valid, req1_ready, req1_in1, req1_in2, req1_func3, req1_opequal  same as requester 0, for requester 1
- alu_in1  out  XLEN  to ALU in1
- alu_in2  out  XLEN  to ALU in2
- alu_func3  out  3  to ALU func3
- alu_opequal  out  1  to ALU opequal
- alu_out  in  XLEN  from ALU result
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  XLEN  registered ALU result
- rsp_id  out  1  requester that issued the result
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (async, rst_n low):
  - state is IDLE; rsp_valid, rsp_data, rsp_id and busy are 0.
  - alu_in1, alu_in2, alu_func3 and alu_opequal are 0.
  - Priority pointer points to requester 0.
- States:
  - IDLE: no op in flight.
  - EXEC: operands registered; ALU inputs driven from the registers.
  - RESP: result held.
- accept = (state==IDLE) or (state==RESP and rsp_ready).
- Grant, combinational:
  - Only one reqN_ready is high per cycle, and only when accept=1 and reqN_valid=1.
  - If both requesters are valid, the priority-pointer side wins.
  - If one requester is valid, it wins regardless of the pointer.
- On a grant:
  - Latch in1, in2, func3, opequal and id into the operand registers (these drive alu_*).
  - Go to EXEC.
  - Toggle the pointer to the non-granted side (round-robin; see Optional Feature).
- EXEC, exactly 1 cycle: rsp_data <= alu_out, rsp_id <= latched id, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id stay stable while rsp_ready=0, for any number of cycles.
  - rsp_ready=1 with a new grant in the same cycle: go directly to EXEC, and rsp_valid drops the next cycle.
  - rsp_ready=1 with no grant: go to IDLE, rsp_valid <= 0.
- Latency and throughput:
  - Grant at cycle N gives rsp_valid at N+2.
  - Sustained throughput is 1 op per 2 cycles with rsp_ready held 1.
- alu_* outputs hold their last operands in IDLE/RESP; they do not return to 0 except on reset.
- No reqN_ready is asserted during EXEC, or during RESP with rsp_ready=0.
- Requesters must hold their request fields stable while valid and not ready.
- func3/opequal are passed unmodified; the block does not decode them.
- Reset mid-operation (EXEC or RESP) discards the op: no response, state IDLE, pointer to requester 0.
- busy = (state != IDLE).

Optional Feature:
- ALU_ARB_RR_EN defined: round-robin. The pointer toggles to the non-granted requester after every grant.
- Undefined: fixed priority. Requester 0 always wins when both are valid; the pointer is unused (constant 0).

Test Plan:
- Single op: req0 ADD in1=5, in2=3, func3=000, opequal=0 granted at cycle N -> alu_in1=5 / alu_in2=3 during N+1; rsp_valid at N+2 with rsp_data=8 (from the ALU model), rsp_id=0; busy high N+1..until the response handshake.
- Contention: req0 and req1 continuously valid, rsp_ready=1.
  - With ALU_ARB_RR_EN: grants alternate 0,1,0,1; rsp_id alternates; one response every 2 cycles.
  - Without it: every grant goes to req0; req1 is never granted.
- Backpressure: req1 SUB 10-4 (opequal=1) completes, rsp_ready held 0 for 5 cycles -> rsp_valid=1, rsp_data=6, rsp_id=1 stable all 5 cycles; no reqN_ready; on rsp_ready=1 the handshake completes.
- Back-to-back: rsp_ready=1 in RESP while req0 is valid with SRA in1=0x80000000, in2=4, func3=101, opequal=1 -> same-cycle grant, state RESP->EXEC, next rsp_data=0xF8000000.
- Reset mid-op: assert rst_n=0 while in EXEC -> all outputs 0 immediately (async); after release, no stale response appears; the first grant goes to req0 when both requesters are valid.
